if_fetch_stage: RTL and testbench

//  Instruction-fetch stage directly downstream of the PC register: takes PC data_out, issues word reads to

---
 rtl/if_fetch_stage_pkg.sv | 19 +
 rtl/if_fetch_stage_if_id_reg.sv | 32 +++
 rtl/if_fetch_stage.sv | 148 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: default widths, NOP encoding and fetch FSM states.
package if_fetch_stage_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned STATE_W    = 3;

    // sll $0,$0,0
    localparam logic [DEF_DATA_W-1:0] DEF_NOP_INSN = 32'h0000_0000;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset loads NOP, clear drops valid only, load captures a new instruction.
module if_id_reg #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter logic [DATA_W-1:0] NOP_INSN = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [ADDR_W-1:0] pc4_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pc4_o
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            instr_o <= NOP_INSN;
            pc4_o   <= '0;
        end else if (clear_i) begin
            valid_o <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            instr_o <= instr_i;
            pc4_o   <= pc4_i;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC -> imem req/ack -> IF/ID, with decode stall hold buffer and branch flush.
// Optional FETCH_STATS_EN adds fetch_cnt / stall_cnt outputs.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSN = DEF_NOP_INSN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              id_stall,
    input  logic              flush,
    output logic              if_id_valid,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0] hold_pc4_q, hold_pc4_d;
    logic [ADDR_W-1:0] pc_word, pc_plus4;
    logic              load_c, clear_c, consume_c;
    logic [DATA_W-1:0] load_instr_c;
    logic [ADDR_W-1:0] load_pc4_c;

    assign pc_word   = pc & ~ADDR_W'(3);
    assign pc_plus4  = pc_word + ADDR_W'(4);
    assign consume_c = if_id_valid && !id_stall;

    // The HOLD state itself marks the hold buffer as occupied.
    always_comb begin
        state_d      = state_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        pc_en        = 1'b0;
        load_c       = 1'b0;
        load_instr_c = imem_rdata;
        load_pc4_c   = pc_plus4;
        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH, ST_WAIT: begin
                if (flush) begin
                    state_d = imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (imem_ack) begin
                    pc_en = 1'b1;
                    if (!if_id_valid || !id_stall) begin
                        load_c  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc4_d   = pc_plus4;
                        state_d      = ST_HOLD;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    state_d = ST_FETCH;
                end else if (!id_stall) begin
                    load_c       = 1'b1;
                    load_instr_c = hold_instr_q;
                    load_pc4_c   = hold_pc4_q;
                    state_d      = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
        clear_c = flush || (consume_c && !load_c);
    end

    // DRAIN keeps presenting the abandoned address while the PC may already hold the branch target.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = '0;
        unique case (state_q)
            ST_FETCH, ST_WAIT: begin
                imem_req  = 1'b1;
                imem_addr = pc_word;
            end
            ST_DRAIN: begin
                imem_req  = 1'b1;
                imem_addr = addr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            hold_instr_q <= NOP_INSN;
            hold_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
            if (state_q == ST_FETCH || state_q == ST_WAIT) addr_q <= pc_word;
        end
    end

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NOP_INSN (NOP_INSN)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_c),
        .clear_i (clear_c),
        .instr_i (load_instr_c),
        .pc4_i   (load_pc4_c),
        .valid_o (if_id_valid),
        .instr_o (if_id_instr),
        .pc4_o   (if_id_pc4)
    );

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (pc_en) fetch_cnt <= fetch_cnt + 32'd1;
            if ((imem_req && !imem_ack) || state_q == ST_HOLD) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: reset, zero-wait stream, wait states, stall/hold, flush, PC wrap.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_stall;
    logic        flush;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    if_fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .id_stall    (id_stall),
        .flush       (flush),
        .if_id_valid (if_id_valid),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4)
`ifdef FETCH_STATS_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and registered outputs are read 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational outputs are read mid-cycle, after inputs have settled.
    task automatic settle();
        #3;
    endtask

    initial begin
        rst = 1'b1; pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
        id_stall = 1'b0; flush = 1'b0;

        // 1: reset
        tick(); tick();
        chk("rst_pc_en", 32'(pc_en), 32'h0);
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        rst = 1'b0;
        settle();
        chk("idle_req", 32'(imem_req), 32'h0);
        tick();
        chk("fetch_req", 32'(imem_req), 32'h1);
        chk("fetch_addr0", imem_addr, 32'h0);

        // 2: zero-wait stream
        for (int i = 0; i < 3; i++) begin
            imem_ack = 1'b1; imem_rdata = 32'h2001000A + 32'(i);
            settle();
            chk("zw_pc_en", 32'(pc_en), 32'h1);
            chk("zw_addr", imem_addr, pc);
            tick();
            chk("zw_valid", 32'(if_id_valid), 32'h1);
            chk("zw_instr", if_id_instr, 32'h2001000A + 32'(i));
            chk("zw_pc4", if_id_pc4, pc + 32'd4);
            pc = pc + 32'd4;
        end

        // 3: wait states, ack on the fourth cycle
        imem_ack = 1'b0; pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ws_addr", imem_addr, 32'h40);
            chk("ws_pc_en", 32'(pc_en), 32'h0);
            tick();
        end
        chk("ws_drop_valid", 32'(if_id_valid), 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        settle();
        chk("ws_addr_ack", imem_addr, 32'h40);
        chk("ws_pc_en_ack", 32'(pc_en), 32'h1);
        tick();
        chk("ws_pc4", if_id_pc4, 32'h44);
        chk("ws_instr", if_id_instr, 32'h1111_2222);
        pc = 32'h44;

        // 4: stall with IF/ID full -> HOLD
        id_stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h8C22_0004;
        settle();
        chk("hold_pc_en", 32'(pc_en), 32'h1);
        tick();
        imem_ack = 1'b0; pc = 32'h48;
        settle();
        chk("hold_req", 32'(imem_req), 32'h0);
        chk("hold_keep", if_id_instr, 32'h1111_2222);
        tick();
        chk("hold_req2", 32'(imem_req), 32'h0);
        id_stall = 1'b0;
        settle();
        chk("hold_pc_en_rel", 32'(pc_en), 32'h0);
        tick();
        chk("hold_instr", if_id_instr, 32'h8C22_0004);
        chk("hold_pc4", if_id_pc4, 32'h48);
        chk("hold_valid", 32'(if_id_valid), 32'h1);
        chk("resume_req", 32'(imem_req), 32'h1);
        chk("resume_addr", imem_addr, 32'h48);
        imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
        settle();
        chk("resume_pc_en", 32'(pc_en), 32'h1);
        tick();
        chk("resume_instr", if_id_instr, 32'h3333_4444);
        chk("resume_pc4", if_id_pc4, 32'h4C);
        imem_ack = 1'b0; pc = 32'h4C;

        // 5: flush with a request outstanding
        flush = 1'b1;
        settle();
        chk("fl_pc_en", 32'(pc_en), 32'h0);
        tick();
        flush = 1'b0; pc = 32'h100;
        settle();
        chk("fl_valid", 32'(if_id_valid), 32'h0);
        chk("drain_req", 32'(imem_req), 32'h1);
        chk("drain_addr", imem_addr, 32'h4C);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        settle();
        chk("drain_pc_en", 32'(pc_en), 32'h0);
        tick();
        imem_ack = 1'b0;
        settle();
        chk("post_drain_valid", 32'(if_id_valid), 32'h0);
        chk("post_drain_addr", imem_addr, 32'h100);
        chk("post_drain_req", 32'(imem_req), 32'h1);

        // 6: PC wrap and statistics from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef FETCH_STATS_EN
        chk("st_fetch0", fetch_cnt, 32'h0);
        chk("st_stall0", stall_cnt, 32'h0);
`endif
        tick();
        pc = 32'hFFFF_FFFC; imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D;
        tick();
        chk("wrap_pc4", if_id_pc4, 32'h0);
        chk("wrap_valid", 32'(if_id_valid), 32'h1);
        pc = 32'h0; imem_ack = 1'b0;
        tick();
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0001;
        tick();
        chk("wrap_next_pc4", if_id_pc4, 32'h4);
        pc = 32'h4; imem_rdata = 32'h0000_0002;
        tick();
        imem_ack = 1'b0;
`ifdef FETCH_STATS_EN
        chk("st_fetch", fetch_cnt, 32'd3);
        chk("st_stall", stall_cnt, 32'd2);
`endif
        chk("last_instr", if_id_instr, 32'h0000_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
